// File: rtl/buf_elastic.sv
// Registered valid/ready elastic buffer: WIDTH-bit words, DEPTH entries, strict FIFO order.
// The head word is held in an output register, so there is no combinational in->out path.
module buf_elastic #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             live;
  logic             push;
  logic             pop;

  // live holds in_ready low during reset and for the edge on which reset is released
  assign in_ready  = live && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign rd_nxt    = rd_ptr + AW'(1);

  always_ff @(posedge CK) begin
    if (push) mem[wr_ptr] <= in;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // the incoming word becomes the head when the buffer is, or is about to be, empty
      if (push && ((count == '0) || (pop && (count == CNT_W'(1)))))
        out <= in;
      else if (pop && (count > CNT_W'(1)))
        out <= mem[rd_nxt];
    end
  end

`ifdef ENABLE_TIMING
  specify
    (CK => out)       = 0.01;
    (CK => out_valid) = 0.01;
  endspecify
`endif

endmodule
